// File: rtl/game_pkg.sv
// Shared types and constants for the brick-breaker ball sequencer.
//   state_e  : sequencer states
//   hit_e    : classification of one flight step
//   grid rows/limits and clear-row encodings
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AIM,
    ST_FLIGHT,
    ST_CLEAR,
    ST_RESPAWN,
    ST_WIN
  } state_e;

  typedef enum logic [2:0] {
    HIT_NONE,
    HIT_STONE,
    HIT_ROW1,
    HIT_ROW0,
    HIT_MISS
  } hit_e;

  localparam logic [2:0] STONE_Y  = 3'd3;
  localparam logic [2:0] ROW1_Y   = 3'd6;
  localparam logic [2:0] ROW0_Y   = 3'd7;
  localparam logic [2:0] GRID_MAX = 3'd7;

  localparam logic CLR_ROW0 = 1'b0;
  localparam logic CLR_ROW1 = 1'b1;

endpackage

// File: rtl/shot_hit_detect.sv
// Combinational classification of the ball's current cell for one flight step.
//   ball_x, ball_y : current ball position
//   stone_pos      : stone column (stone covers stone_pos and stone_pos+1)
//   brick_row0/1   : far (y=7) and near (y=6) brick rows, bit = column
//   hit            : none / stone / row1 / row0 / miss, in that priority
module shot_hit_detect
  import game_pkg::*;
(
  input  logic [2:0] ball_x,
  input  logic [2:0] ball_y,
  input  logic [2:0] stone_pos,
  input  logic [7:0] brick_row0,
  input  logic [7:0] brick_row1,
  output hit_e       hit
);

  logic stone_hit;

  always_comb begin
    // The stone is two cells wide, so the ball is blocked when it sits on
    // either the stone's own column or the one to its right.
    stone_hit = (stone_pos == ball_x) ||
                ((ball_x != 3'd0) && (stone_pos == (ball_x - 3'd1)));
    hit = HIT_NONE;
    if ((ball_y == STONE_Y) && stone_hit) begin
      hit = HIT_STONE;
    end else if ((ball_y == ROW1_Y) && brick_row1[ball_x]) begin
      hit = HIT_ROW1;
    end else if ((ball_y == ROW0_Y) && brick_row0[ball_x]) begin
      hit = HIT_ROW0;
    end else if (ball_y == ROW0_Y) begin
      hit = HIT_MISS;
    end
  end

endmodule

// File: rtl/shot_sequencer.sv
// Ball sequencer for the brick-breaker game: aim, throw, flight, impact,
// clear request, respawn and win detection.
//   CLK, reset        : clock, synchronous active-high reset
//   restart           : game restart (also pulses brick_reload)
//   start             : run enable, low freezes the block
//   tick              : step strobe; left/right/throw sampled on it
//   stone_pos         : stone column
//   brick_row0/1      : current brick rows from the datapath
//   clr_valid/ready   : clear handshake, clr_row/clr_col name the hit brick
//   brick_reload      : one-cycle refill pulse on restart
//   ball_x/y, in_hand : ball state
//   shot_count        : shots fired, wraps at MAX_SHOTS
//   game_over         : all bricks cleared
module shot_sequencer
  import game_pkg::*;
#(
  parameter int unsigned STEP_DIV  = 3,
  parameter int unsigned X_HOME    = 2,
  parameter int unsigned Y_HOME    = 2,
  parameter int unsigned MAX_SHOTS = 10
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       restart,
  input  logic       start,
  input  logic       tick,
  input  logic       left,
  input  logic       right,
  input  logic       throw,
  input  logic [2:0] stone_pos,
  input  logic [7:0] brick_row0,
  input  logic [7:0] brick_row1,
  output logic       clr_valid,
  input  logic       clr_ready,
  output logic       clr_row,
  output logic [2:0] clr_col,
  output logic       brick_reload,
  output logic [2:0] ball_x,
  output logic [2:0] ball_y,
  output logic       in_hand,
  output logic [3:0] shot_count,
  output logic       game_over
);

  localparam int unsigned SW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [2:0]    XH        = 3'(X_HOME);
  localparam logic [2:0]    YH        = 3'(Y_HOME);
  localparam logic [3:0]    SHOT_LAST = 4'(MAX_SHOTS - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

  state_e        state_q, state_d;
  logic [2:0]    ball_x_q, ball_x_d;
  logic [2:0]    ball_y_q, ball_y_d;
  logic          in_hand_q, in_hand_d;
  logic [3:0]    shot_q, shot_d;
  logic          game_over_q, game_over_d;
  logic          clr_valid_q, clr_valid_d;
  logic          clr_row_q, clr_row_d;
  logic [2:0]    clr_col_q, clr_col_d;
  logic          reload_q, reload_d;
  logic [SW-1:0] step_q, step_d;
  hit_e          hit;

  shot_hit_detect u_hit (
    .ball_x     (ball_x_q),
    .ball_y     (ball_y_q),
    .stone_pos  (stone_pos),
    .brick_row0 (brick_row0),
    .brick_row1 (brick_row1),
    .hit        (hit)
  );

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    in_hand_d   = in_hand_q;
    shot_d      = shot_q;
    game_over_d = game_over_q;
    clr_valid_d = clr_valid_q;
    clr_row_d   = clr_row_q;
    clr_col_d   = clr_col_q;
    reload_d    = 1'b0;
    step_d      = step_q;

    if (restart) begin
      state_d     = start ? ST_AIM : ST_IDLE;
      ball_x_d    = XH;
      ball_y_d    = YH;
      in_hand_d   = 1'b1;
      shot_d      = '0;
      game_over_d = 1'b0;
      clr_valid_d = 1'b0;
      reload_d    = 1'b1;
      step_d      = '0;
    end else if (state_q == ST_CLEAR) begin
      // Accept is honoured even with start low: the datapath registers the
      // clear on valid&&ready regardless, so both sides must agree it happened.
      if (clr_valid_q && clr_ready) begin
        clr_valid_d = 1'b0;
        state_d     = ST_RESPAWN;
        ball_x_d    = XH;
        ball_y_d    = YH;
        in_hand_d   = 1'b1;
      end
    end else if (start) begin
      case (state_q)
        ST_IDLE: state_d = ST_AIM;
        ST_AIM: begin
          if (tick) begin
            if (throw) begin
              state_d   = ST_FLIGHT;
              in_hand_d = 1'b0;
              step_d    = '0;
              shot_d    = (shot_q == SHOT_LAST) ? 4'd0 : shot_q + 4'd1;
            end else if (left && !right && (ball_x_q != 3'd0)) begin
              ball_x_d = ball_x_q - 3'd1;
            end else if (right && !left && (ball_x_q != GRID_MAX)) begin
              ball_x_d = ball_x_q + 3'd1;
            end
          end
        end
        ST_FLIGHT: begin
          if (tick) begin
            if (step_q == STEP_LAST) begin
              step_d = '0;
              case (hit)
                HIT_STONE, HIT_MISS: begin
                  state_d   = ST_RESPAWN;
                  ball_x_d  = XH;
                  ball_y_d  = YH;
                  in_hand_d = 1'b1;
                end
                HIT_ROW1: begin
                  state_d     = ST_CLEAR;
                  clr_valid_d = 1'b1;
                  clr_row_d   = CLR_ROW1;
                  clr_col_d   = ball_x_q;
                end
                HIT_ROW0: begin
                  state_d     = ST_CLEAR;
                  clr_valid_d = 1'b1;
                  clr_row_d   = CLR_ROW0;
                  clr_col_d   = ball_x_q;
                end
                default: ball_y_d = ball_y_q + 3'd1;
              endcase
            end else begin
              step_d = step_q + SW'(1);
            end
          end
        end
        ST_RESPAWN: begin
          ball_x_d  = XH;
          ball_y_d  = YH;
          in_hand_d = 1'b1;
          if ((brick_row0 | brick_row1) == '0) begin
            state_d     = ST_WIN;
            game_over_d = 1'b1;
          end else begin
            state_d = ST_AIM;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ball_x_q    <= XH;
      ball_y_q    <= YH;
      in_hand_q   <= 1'b1;
      shot_q      <= '0;
      game_over_q <= 1'b0;
      clr_valid_q <= 1'b0;
      clr_row_q   <= CLR_ROW0;
      clr_col_q   <= '0;
      reload_q    <= 1'b0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      in_hand_q   <= in_hand_d;
      shot_q      <= shot_d;
      game_over_q <= game_over_d;
      clr_valid_q <= clr_valid_d;
      clr_row_q   <= clr_row_d;
      clr_col_q   <= clr_col_d;
      reload_q    <= reload_d;
      step_q      <= step_d;
    end
  end

  assign clr_valid    = clr_valid_q;
  assign clr_row      = clr_row_q;
  assign clr_col      = clr_col_q;
  assign brick_reload = reload_q;
  assign ball_x       = ball_x_q;
  assign ball_y       = ball_y_q;
  assign in_hand      = in_hand_q;
  assign shot_count   = shot_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Self-checking bench for shot_sequencer. Expected clear requests are queued
// when a throw is made and popped when the handshake completes; the bench
// also models the brick datapath so the win condition arises naturally.
module tb_shot_sequencer;

  localparam int STEP_DIV  = 3;
  localparam int X_HOME    = 2;
  localparam int Y_HOME    = 2;
  localparam int MAX_SHOTS = 10;

  typedef struct packed {
    logic       row;
    logic [2:0] col;
  } clr_t;

  logic       CLK = 1'b0;
  logic       reset, restart, start, tick, left, right, throw;
  logic [2:0] stone_pos;
  logic [7:0] row0, row1;
  logic       clr_ready;
  logic       clr_valid, clr_row, brick_reload, in_hand, game_over;
  logic [2:0] clr_col, ball_x, ball_y;
  logic [3:0] shot_count;

  int   n_total = 0;
  int   n_bad   = 0;
  clr_t sb[$];
  int   ex;
  int   exp_shot;

  shot_sequencer #(
    .STEP_DIV  (STEP_DIV),
    .X_HOME    (X_HOME),
    .Y_HOME    (Y_HOME),
    .MAX_SHOTS (MAX_SHOTS)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .restart      (restart),
    .start        (start),
    .tick         (tick),
    .left         (left),
    .right        (right),
    .throw        (throw),
    .stone_pos    (stone_pos),
    .brick_row0   (row0),
    .brick_row1   (row1),
    .clr_valid    (clr_valid),
    .clr_ready    (clr_ready),
    .clr_row      (clr_row),
    .clr_col      (clr_col),
    .brick_reload (brick_reload),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .in_hand      (in_hand),
    .shot_count   (shot_count),
    .game_over    (game_over)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; completes a pending handshake against the scoreboard and the
  // brick model using the values present before the edge.
  task automatic cyc();
    logic       acc, rl, crow;
    logic [2:0] ccol;
    clr_t       e;
    acc  = clr_valid && clr_ready;
    rl   = brick_reload;
    crow = clr_row;
    ccol = clr_col;
    @(posedge CLK);
    #1;
    if (acc) begin
      check_eq("sb_has_entry", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("sb_row", int'(crow), int'(e.row));
        check_eq("sb_col", int'(ccol), int'(e.col));
      end
      for (int c = int'(ccol) - 1; c <= int'(ccol) + 1; c++) begin
        if (c >= 0 && c <= 7) begin
          if (crow) row1[c] = 1'b0;
          else      row0[c] = 1'b0;
        end
      end
      if (crow) row0[ccol] = 1'b0;
    end
    if (rl) begin
      row0 = '1;
      row1 = '1;
    end
  endtask

  task automatic do_tick(input logic l, input logic r, input logic t);
    tick = 1'b1; left = l; right = r; throw = t;
    cyc();
    tick = 1'b0; left = 1'b0; right = 1'b0; throw = 1'b0;
  endtask

  // Expected outcome of a throw from column x: -1 none, 0 row0, 1 row1.
  function automatic int predict(input int x, input int sp,
                                 input logic [7:0] r0, input logic [7:0] r1,
                                 output int ticks);
    ticks = 0;
    for (int y = Y_HOME; y <= 7; y++) begin
      ticks += STEP_DIV;
      if (y == 3 && (sp == x || (x > 0 && sp == x - 1))) return -1;
      if (y == 6 && r1[x]) return 1;
      if (y == 7) return r0[x] ? 0 : -1;
    end
    return -1;
  endfunction

  task automatic fly(input int exp_ticks, input int cls);
    int n;
    n = 0;
    do begin
      do_tick(1'b0, 1'b0, 1'b0);
      n++;
    end while (!clr_valid && !in_hand && n < 200);
    check_eq("fly_ticks", n, exp_ticks);
    check_eq("fly_clr", int'(clr_valid), int'(cls >= 0));
    if (cls < 0) check_eq("respawn_y", int'(ball_y), Y_HOME);
  endtask

  task automatic throw_and_push(output int tk, output int cls);
    clr_t e;
    cls = predict(ex, int'(stone_pos), row0, row1, tk);
    if (cls >= 0) begin
      e.row = (cls == 1);
      e.col = 3'(ex);
      sb.push_back(e);
    end
    exp_shot = (exp_shot + 1) % MAX_SHOTS;
    do_tick(1'b0, 1'b0, 1'b1);
    check_eq("throw_in_hand", int'(in_hand), 0);
    check_eq("throw_shots", int'(shot_count), exp_shot);
  endtask

  task automatic shoot();
    int tk, cls;
    throw_and_push(tk, cls);
    fly(tk, cls);
  endtask

  task automatic accept_and_respawn();
    clr_ready = 1'b1;
    cyc();
    check_eq("accept_drop", int'(clr_valid), 0);
    cyc();
    ex = X_HOME;
    check_eq("resp_in_hand", int'(in_hand), 1);
    check_eq("resp_x", int'(ball_x), X_HOME);
    check_eq("resp_y", int'(ball_y), Y_HOME);
  endtask

  task automatic respawn_only();
    cyc();
    ex = X_HOME;
    check_eq("resp_in_hand", int'(in_hand), 1);
    check_eq("resp_x", int'(ball_x), X_HOME);
  endtask

  initial begin
    int tk, cls;
    reset = 1'b1; restart = 1'b0; start = 1'b0;
    tick = 1'b0; left = 1'b0; right = 1'b0; throw = 1'b0;
    stone_pos = 3'd5; row0 = '1; row1 = '1; clr_ready = 1'b0;
    ex = X_HOME; exp_shot = 0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check_eq("rst_x", int'(ball_x), X_HOME);
    check_eq("rst_y", int'(ball_y), Y_HOME);
    check_eq("rst_in_hand", int'(in_hand), 1);
    check_eq("rst_shots", int'(shot_count), 0);
    check_eq("rst_game_over", int'(game_over), 0);
    check_eq("rst_clr_valid", int'(clr_valid), 0);
    check_eq("rst_reload", int'(brick_reload), 0);
    do_tick(1'b1, 1'b0, 1'b0);
    check_eq("idle_ignores_tick", int'(ball_x), X_HOME);

    // Aim with clamping at both edges.
    start = 1'b1;
    cyc();
    repeat (3) do_tick(1'b1, 1'b0, 1'b0);
    check_eq("aim_left_clamp", int'(ball_x), 0);
    do_tick(1'b1, 1'b0, 1'b0);
    check_eq("aim_left_stay", int'(ball_x), 0);
    repeat (9) do_tick(1'b0, 1'b1, 1'b0);
    check_eq("aim_right_clamp", int'(ball_x), 7);
    do_tick(1'b1, 1'b1, 1'b0);
    check_eq("aim_both", int'(ball_x), 7);
    repeat (5) do_tick(1'b1, 1'b0, 1'b0);
    check_eq("aim_back_home", int'(ball_x), 2);
    ex = 2;

    // Near brick with a stalled handshake, including a start=0 stretch.
    shoot();
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_eq("stall_valid", int'(clr_valid), 1);
      check_eq("stall_row", int'(clr_row), 1);
      check_eq("stall_col", int'(clr_col), 2);
    end
    start = 1'b0;
    repeat (2) begin
      cyc();
      check_eq("nostart_valid", int'(clr_valid), 1);
    end
    start = 1'b1;
    accept_and_respawn();
    do_tick(1'b0, 1'b1, 1'b0);
    check_eq("aim_after_respawn", int'(ball_x), 3);
    do_tick(1'b1, 1'b0, 1'b0);
    ex = 2;

    // Far brick, then a clean miss in the same column.
    row0 = '1; row1 = 8'hFB;
    shoot();
    accept_and_respawn();
    shoot();
    respawn_only();

    // Stone hit, then stone out of reach at column 0.
    stone_pos = 3'd1;
    shoot();
    respawn_only();
    stone_pos = 3'd7;
    do_tick(1'b1, 1'b0, 1'b0);
    do_tick(1'b1, 1'b0, 1'b0);
    ex = 0;
    check_eq("aim_to_col0", int'(ball_x), 0);
    shoot();
    accept_and_respawn();

    // Shot counter wrap: five quick stone-blocked throws take 5 -> 0.
    stone_pos = 3'd2;
    repeat (5) begin
      shoot();
      respawn_only();
    end
    check_eq("shot_wrapped", int'(shot_count), 0);

    // Freeze mid-flight.
    stone_pos = 3'd5;
    throw_and_push(tk, cls);
    repeat (4) do_tick(1'b0, 1'b0, 1'b0);
    check_eq("pre_freeze_y", int'(ball_y), 3);
    start = 1'b0;
    repeat (20) do_tick(1'b0, 1'b0, 1'b0);
    check_eq("freeze_y", int'(ball_y), 3);
    check_eq("freeze_in_hand", int'(in_hand), 0);
    start = 1'b1;
    fly(tk - 4, cls);
    if (cls >= 0) accept_and_respawn();
    else          respawn_only();

    // Last brick cleared -> WIN.
    row0 = 8'h04; row1 = 8'h00;
    shoot();
    cyc();
    check_eq("last_accept_drop", int'(clr_valid), 0);
    check_eq("pre_win_flag", int'(game_over), 0);
    cyc();
    check_eq("win_flag", int'(game_over), 1);
    do_tick(1'b1, 1'b0, 1'b1);
    check_eq("win_ignore_x", int'(ball_x), X_HOME);
    check_eq("win_ignore_hand", int'(in_hand), 1);
    check_eq("win_ignore_shots", int'(shot_count), exp_shot);
    check_eq("win_hold", int'(game_over), 1);

    // Restart.
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    exp_shot = 0;
    check_eq("rs_game_over", int'(game_over), 0);
    check_eq("rs_reload", int'(brick_reload), 1);
    check_eq("rs_shots", int'(shot_count), 0);
    check_eq("rs_in_hand", int'(in_hand), 1);
    cyc();
    check_eq("rs_reload_pulse", int'(brick_reload), 0);
    do_tick(1'b0, 1'b1, 1'b0);
    check_eq("aim_after_restart", int'(ball_x), 3);
    ex = 3;

    // Reset while a clear is pending drops the request.
    clr_ready = 1'b0;
    shoot();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sb.delete();
    check_eq("rst_mid_clear_valid", int'(clr_valid), 0);
    check_eq("rst_mid_clear_x", int'(ball_x), X_HOME);
    check_eq("rst_mid_clear_shots", int'(shot_count), 0);
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
